// File: rtl/nes_poll_sequencer.sv
// NES controller poll sequencer: drives latch/pulse from tick_en strobes and publishes the button byte.
// Optional POLL_DEBOUNCE_EN: publish only when two consecutive polls return the same raw byte.
module nes_poll_sequencer #(
  parameter int unsigned LATCH_TICKS       = 2,
  parameter int unsigned HALF_TICKS        = 1,
  parameter int unsigned POLL_PERIOD_TICKS = 1067
) (
  input  logic       clock_2MHz,
  input  logic       reset_n,
  input  logic       tick_en,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned PER_W  = (POLL_PERIOD_TICKS > 1) ? $clog2(POLL_PERIOD_TICKS) : 1;
  localparam int unsigned PH_MAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD_TICKS - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_TICKS - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [PER_W-1:0] per_cnt;
  logic [PH_W-1:0]  phase;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             sync_meta;
  logic             sync_data;
  logic             wrap;

  // Two-flop synchronizer; idles released (high) like an unplugged controller line
  always_ff @(posedge clock_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      sync_data <= 1'b1;
    end else begin
      sync_meta <= nes_data;
      sync_data <= sync_meta;
    end
  end

  assign wrap = tick_en && (per_cnt == PER_LAST);

  // Free-running poll period counter
  always_ff @(posedge clock_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (tick_en) begin
      per_cnt <= wrap ? '0 : per_cnt + PER_W'(1);
    end
  end

`ifdef POLL_DEBOUNCE_EN
  logic [7:0] raw_prev;
`endif

  // Poll FSM with registered latch/pulse/busy/result outputs
  always_ff @(posedge clock_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      phase         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      nes_latch     <= 1'b0;
      nes_pulse     <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef POLL_DEBOUNCE_EN
      raw_prev      <= '0;
`endif
    end else begin
      buttons_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wrap) begin
            state     <= S_LATCH;
            phase     <= '0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LATCH: begin
          if (tick_en) begin
            if (phase == LATCH_LAST) begin
              state     <= S_LOW;
              phase     <= '0;
              bit_idx   <= '0;
              nes_latch <= 1'b0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        S_LOW: begin
          if (tick_en) begin
            if (phase == HALF_LAST) begin
              shreg[bit_idx] <= ~sync_data;
              phase          <= '0;
              if (bit_idx == 3'd7) begin
                state <= S_DONE;
              end else begin
                state     <= S_HIGH;
                nes_pulse <= 1'b1;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (tick_en) begin
            if (phase == HALF_LAST) begin
              state     <= S_LOW;
              phase     <= '0;
              bit_idx   <= bit_idx + 3'd1;
              nes_pulse <= 1'b0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          phase <= '0;
          busy  <= 1'b0;
`ifdef POLL_DEBOUNCE_EN
          raw_prev <= shreg;
          if (shreg == raw_prev) begin
            buttons       <= shreg;
            buttons_valid <= 1'b1;
          end
`else
          buttons       <= shreg;
          buttons_valid <= 1'b1;
`endif
        end
        default: begin
          state     <= S_IDLE;
          phase     <= '0;
          nes_latch <= 1'b0;
          nes_pulse <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Randomized bench for nes_poll_sequencer: tick-count reference model plus a reactive controller model.
module tb_nes_poll_sequencer;

  localparam int LT = 2;
  localparam int HT = 1;
  localparam int PP = 32;
  localparam int POLL_TICKS = LT + 15 * HT;

  logic       clock_2MHz = 1'b0;
  logic       reset_n;
  logic       tick_en;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       busy;

  always #5 clock_2MHz = ~clock_2MHz;

  nes_poll_sequencer #(
    .LATCH_TICKS      (LT),
    .HALF_TICKS       (HT),
    .POLL_PERIOD_TICKS(PP)
  ) dut (
    .clock_2MHz   (clock_2MHz),
    .reset_n      (reset_n),
    .tick_en      (tick_en),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_pulse    (nes_pulse),
    .buttons      (buttons),
    .buttons_valid(buttons_valid),
    .busy         (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         tc;
  int         tick_div;
  bit         done_prev;
  bit         cont_bytes;
  logic [7:0] exp_buttons;
  logic [7:0] raw_prev;
  logic [7:0] poll_byte;
  logic [7:0] cur_byte;
  logic [7:0] byte_q[$];
  int         idx;
  int         pulse_cnt;
  logic       prev_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick_byte();
    if (byte_q.size() > 0) return byte_q.pop_front();
    if (cont_bytes) return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
`ifdef POLL_DEBOUNCE_EN
    if ($urandom_range(0, 1) == 1) return raw_prev;
`endif
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic model_reset();
    tc          = 0;
    done_prev   = 1'b0;
    exp_buttons = 8'h00;
    raw_prev    = 8'h00;
    idx         = 8;
    pulse_cnt   = 0;
    prev_pulse  = 1'b0;
    nes_data    = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_latch"}, 32'(nes_latch), 32'd0);
    check_eq({tag, "_pulse"}, 32'(nes_pulse), 32'd0);
    check_eq({tag, "_buttons"}, 32'(buttons), 32'd0);
    check_eq({tag, "_valid"}, 32'(buttons_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One clock: drive tick, advance the model, compare every output, then react as a controller
  task automatic cycle(input bit tick);
    int   o;
    int   j;
    bit   done_now;
    bit   pub;
    logic exp_latch, exp_pulse, exp_busy, exp_valid;
    @(negedge clock_2MHz);
    tick_en = tick;
    @(posedge clock_2MHz);
    #1;
    if (tick) tc++;
    o = (tc >= PP) ? (tc % PP) : -1;
    done_now = tick && (o == POLL_TICKS);
    if (tick && o == 0) begin
      poll_byte = pick_byte();
      cur_byte  = poll_byte;
    end
    pub = 1'b0;
    if (done_prev) begin
`ifdef POLL_DEBOUNCE_EN
      pub      = (poll_byte == raw_prev);
      raw_prev = poll_byte;
`else
      pub = 1'b1;
`endif
      if (pub) exp_buttons = poll_byte;
      check_eq("pulse_count", 32'(pulse_cnt), 32'd7);
    end
    j         = o - LT;
    exp_latch = (o >= 0) && (o < LT);
    exp_pulse = (o >= LT) && (o < POLL_TICKS) && (((j / HT) % 2) == 1);
    exp_busy  = ((o >= 0) && (o < POLL_TICKS)) || done_now;
    exp_valid = pub;
    check_eq("nes_latch", 32'(nes_latch), 32'(exp_latch));
    check_eq("nes_pulse", 32'(nes_pulse), 32'(exp_pulse));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("buttons_valid", 32'(buttons_valid), 32'(exp_valid));
    check_eq("buttons", 32'(buttons), 32'(exp_buttons));
    done_prev = done_now;
    if (nes_latch) begin
      idx       = 0;
      pulse_cnt = 0;
    end else if (nes_pulse && !prev_pulse) begin
      idx++;
      pulse_cnt++;
    end
    prev_pulse = nes_pulse;
    nes_data   = (idx < 8) ? ~cur_byte[idx] : 1'b1;
  endtask

  task automatic step(input int spacing);
    tick_div++;
    cycle((tick_div % spacing) == 0);
  endtask

  task automatic run(input int n, input int spacing);
    for (int i = 0; i < n; i++) step(spacing);
  endtask

  // Advance with 4-clock ticks until the model sits at poll offset `target`
  task automatic run_to_offset(input string tag, input int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step(4);
      if (tc >= PP && (tc % PP) == target) begin
        found = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    tick_en    = 1'b0;
    tick_div   = 0;
    cont_bytes = 1'b0;
    cur_byte   = 8'h00;
    poll_byte  = 8'h00;
    model_reset();
`ifdef POLL_DEBOUNCE_EN
    byte_q = '{8'h01, 8'h03, 8'h03};
`else
    byte_q = '{8'h5A, 8'h00};
`endif
    repeat (3) @(negedge clock_2MHz);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Idle stretch, directed polls, then random polls at one tick per 4 clocks
    run(6 * PP * 4 + 80, 4);

    // Asynchronous reset while HIGH after bit 4 has been sampled
    run_to_offset("reach_high_bit4", LT + 9 * HT);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    tick_en = 1'b1;
    repeat (3) @(negedge clock_2MHz);
    reset_n = 1'b0;
    tick_en = 1'b0;
    @(negedge clock_2MHz);
    reset_n = 1'b1;
    run(2 * PP * 4 + 80, 4);

    // Continuous ticks, switched in and out only while idle
    run_to_offset("idle_before_cont", POLL_TICKS + 3);
    cont_bytes = 1'b1;
    run(4 * PP + 10, 1);
    run_to_offset("idle_after_cont", POLL_TICKS + 3);
    cont_bytes = 1'b0;
    run(2 * PP * 4 + 40, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
